// File: rtl/spi_resp_pkg.sv
// ============================================================================
//  Module      : spi_resp_pkg
//  Description : Shared types and constants for the SPI target responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_resp_pkg;

    typedef enum logic [1:0] {
        WAIT_DESEL = 2'd0,
        IDLE       = 2'd1,
        SHIFT      = 2'd2
    } state_t;

    localparam int SPI_SYNC_STAGES = 2;
    localparam int FRAME_CNT_W     = 16;

endpackage

`default_nettype wire

// File: rtl/spi_resp_sync.sv
// ============================================================================
//  Module      : spi_resp_sync
//  Description : Multi-flop synchroniser for one async pin, with optional
//                rise/fall pulse generation from one extra history flop.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_resp_sync #(
    parameter int STAGES      = 2,
    parameter bit EDGE_DETECT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES-1];

    generate
        if (EDGE_DETECT) begin : g_edge
            logic r_prev;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_prev <= 1'b0;
                end else begin
                    r_prev <= o_sync;
                end
            end

            assign o_rise = o_sync & ~r_prev;
            assign o_fall = ~o_sync & r_prev;
        end else begin : g_no_edge
            assign o_rise = 1'b0;
            assign o_fall = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/spi_target_responder.sv
// ============================================================================
//  Module      : spi_target_responder
//  Description : Mode-0 SPI target oversampled in the clk domain; receives
//                MOSI frames and answers on MISO from a one-word buffer.
//                SPI_RESP_LOOPBACK_EN: echo last rx word when buffer is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_target_responder
    import spi_resp_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                SS_INDEX  = 0,
    parameter logic [DATA_W-1:0] IDLE_BYTE = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   spi_sclk,
    input  logic [2:0]             spi_ss,
    input  logic                   spi_mosi,
    output logic                   spi_miso,
    output logic                   spi_miso_oe,
    input  logic [DATA_W-1:0]      tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [DATA_W-1:0]      rx_data,
    output logic                   rx_valid,
    output logic                   frame_err,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int                c_CNT_W = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_W - 1);

    logic [2:0] w_ss_unused;
    logic       w_sclk_rise, w_sclk_fall, w_sclk_lvl_unused;
    logic       w_ss_sel, w_ss_fall, w_ss_rise_unused;
    logic       w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    assign w_ss_unused = spi_ss;

    spi_resp_sync #(.STAGES(SPI_SYNC_STAGES), .EDGE_DETECT(1'b1)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_async(spi_sclk),
        .o_sync(w_sclk_lvl_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    // Reset value 0 keeps WAIT_DESEL from arming until a genuine deselect is seen
    spi_resp_sync #(.STAGES(SPI_SYNC_STAGES), .EDGE_DETECT(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .i_async(spi_ss[SS_INDEX]),
        .o_sync(w_ss_sel), .o_rise(w_ss_rise_unused), .o_fall(w_ss_fall)
    );

    spi_resp_sync #(.STAGES(SPI_SYNC_STAGES), .EDGE_DETECT(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .i_async(spi_mosi),
        .o_sync(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
    );

    state_t                 r_state, w_next_state;
    logic [DATA_W-1:0]      r_rx_shift, r_tx_shift, r_rx_data, r_buf;
    logic [c_CNT_W-1:0]     r_bit_cnt;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   r_pending, r_reload_pend, r_miso_oe, r_rx_valid, r_frame_err;

    logic w_load_start, w_rx_bit, w_complete, w_tx_shift, w_tx_reload, w_err, w_oe_next;
    logic w_load, w_tx_wr;
    logic [DATA_W-1:0] w_fallback, w_load_word, w_rx_next;

`ifdef SPI_RESP_LOOPBACK_EN
    assign w_fallback = r_rx_data;
`else
    assign w_fallback = IDLE_BYTE;
`endif

    assign w_load      = w_load_start | w_tx_reload;
    assign w_load_word = r_pending ? r_buf : w_fallback;
    assign w_tx_wr     = tx_valid & ~r_pending;
    assign w_rx_next   = {r_rx_shift[DATA_W-2:0], w_mosi};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_DESEL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load_start = 1'b0;
        w_rx_bit     = 1'b0;
        w_complete   = 1'b0;
        w_tx_shift   = 1'b0;
        w_tx_reload  = 1'b0;
        w_err        = 1'b0;
        w_oe_next    = 1'b0;
        case (r_state)
            WAIT_DESEL: begin
                if (w_ss_sel) w_next_state = IDLE;
            end
            IDLE: begin
                if (w_ss_fall) begin
                    w_load_start = 1'b1;
                    w_oe_next    = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                w_oe_next = 1'b1;
                if (w_sclk_rise) begin
                    w_rx_bit   = 1'b1;
                    w_complete = (r_bit_cnt == c_LAST);
                end
                if (w_sclk_fall) begin
                    w_tx_reload = r_reload_pend;
                    w_tx_shift  = ~r_reload_pend;
                end
                // A final rise coinciding with deselect still completes cleanly
                if (w_ss_sel) begin
                    w_next_state = IDLE;
                    w_oe_next    = 1'b0;
                    w_tx_reload  = 1'b0;
                    w_tx_shift   = 1'b0;
                    w_err        = (r_bit_cnt != '0) & ~w_complete;
                end
            end
            default: w_next_state = WAIT_DESEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_rx_data     <= '0;
            r_buf         <= '0;
            r_bit_cnt     <= '0;
            r_frame_cnt   <= '0;
            r_pending     <= 1'b0;
            r_reload_pend <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_rx_valid  <= w_complete;
            r_frame_err <= w_err;
            r_miso_oe   <= w_oe_next;

            if (w_load) begin
                r_tx_shift <= w_load_word;
            end else if (w_tx_shift) begin
                r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
            end

            if (w_load_start || w_tx_reload) begin
                r_reload_pend <= 1'b0;
            end

            if (w_load_start) begin
                r_bit_cnt <= '0;
            end else if (w_rx_bit) begin
                r_rx_shift <= w_rx_next;
                if (w_complete) begin
                    r_rx_data     <= w_rx_next;
                    r_frame_cnt   <= r_frame_cnt + FRAME_CNT_W'(1);
                    r_bit_cnt     <= '0;
                    r_reload_pend <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                end
            end

            if (w_tx_wr) begin
                r_buf     <= tx_data;
                r_pending <= 1'b1;
            end else if (w_load) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign spi_miso    = r_tx_shift[DATA_W-1] & r_miso_oe;
    assign spi_miso_oe = r_miso_oe;
    assign tx_ready    = ~r_pending;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign frame_cnt   = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_spi_target_responder.sv
// ============================================================================
//  Module      : tb_spi_target_responder
//  Description : Directed self-checking bench for spi_target_responder;
//                honours SPI_RESP_LOOPBACK_EN for the fallback word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_target_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_sclk;
    logic [2:0]  spi_ss;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic [15:0] frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int rxv_cnt = 0;
    int err_cnt = 0;

    spi_target_responder dut (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_ss(spi_ss),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1)  rxv_cnt <= rxv_cnt + 1;
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mode 0: MOSI set on the falling side, MISO sampled just before the rise
    task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = mo[i];
            tick(4);
            mi[i]    = spi_miso;
            spi_sclk = 1'b1;
            tick(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic ss_low();
        spi_ss[0] = 1'b0;
        tick(6);
    endtask

    task automatic ss_high();
        tick(4);
        spi_ss[0] = 1'b1;
        tick(8);
    endtask

    logic [7:0] mi;
    int         rxv0, err0;
    logic [7:0] fb_t2, fb_t3, fb_t5, fb_t6;

    initial begin
`ifdef SPI_RESP_LOOPBACK_EN
        fb_t2 = 8'h96; fb_t3 = 8'h11; fb_t5 = 8'h00; fb_t6 = 8'h0F;
`else
        fb_t2 = 8'hA5; fb_t3 = 8'hA5; fb_t5 = 8'hA5; fb_t6 = 8'hA5;
`endif
        rst = 1'b1; spi_sclk = 1'b0; spi_ss = 3'b111; spi_mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        tick(4);
        rst = 1'b0;
        check("rst_tx_ready", tx_ready, 1);
        check("rst_oe", spi_miso_oe, 0);
        check("rst_miso", spi_miso, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);

        // 1: queued response
        tx_data = 8'h3C; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
        check("t1_tx_ready_busy", tx_ready, 0);
        tick(6);
        ss_low();
        check("t1_oe_sel", spi_miso_oe, 1);
        spi_bits(8'h96, 8, mi);
        check("t1_miso", mi, 8'h3C);
        ss_high();
        check("t1_rx_data", rx_data, 8'h96);
        check("t1_rxv_cnt", rxv_cnt, 1);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_tx_ready", tx_ready, 1);
        check("t1_oe_desel", spi_miso_oe, 0);

        // 2: empty buffer -> fallback word
        ss_low();
        spi_bits(8'h01, 8, mi);
        ss_high();
        check("t2_miso", mi, fb_t2);
        check("t2_rx_data", rx_data, 8'h01);
        check("t2_frame_cnt", frame_cnt, 2);

        // 3: back-to-back frames
        tx_data = 8'hC3; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
        rxv0 = rxv_cnt;
        ss_low();
        spi_bits(8'h11, 8, mi);
        check("t3_miso0", mi, 8'hC3);
        check("t3_tx_ready", tx_ready, 1);
        check("t3_rx_data0", rx_data, 8'h11);
        spi_bits(8'h22, 8, mi);
        check("t3_miso1", mi, fb_t3);
        ss_high();
        check("t3_rx_data1", rx_data, 8'h22);
        check("t3_rxv", rxv_cnt - rxv0, 2);
        check("t3_frame_cnt", frame_cnt, 4);

        // 4: deselect mid-frame
        err0 = err_cnt; rxv0 = rxv_cnt;
        ss_low();
        spi_bits(8'hFF, 5, mi);
        ss_high();
        check("t4_err", err_cnt - err0, 1);
        check("t4_rx_data", rx_data, 8'h22);
        check("t4_frame_cnt", frame_cnt, 4);
        check("t4_rxv", rxv_cnt - rxv0, 0);
        check("t4_oe", spi_miso_oe, 0);

        // 5: reset mid-frame with ss held low
        err0 = err_cnt; rxv0 = rxv_cnt;
        ss_low();
        spi_bits(8'hF0, 4, mi);
        rst = 1'b1; tick(2); rst = 1'b0;
        for (int f = 0; f < 3; f++) spi_bits(8'h5A, 8, mi);
        tick(4);
        check("t5_rxv_held", rxv_cnt - rxv0, 0);
        check("t5_err_held", err_cnt - err0, 0);
        check("t5_frame_cnt0", frame_cnt, 0);
        check("t5_rx_data0", rx_data, 0);
        check("t5_oe_held", spi_miso_oe, 0);
        ss_high();
        ss_low();
        spi_bits(8'h5C, 8, mi);
        ss_high();
        check("t5_miso", mi, fb_t5);
        check("t5_rx_data", rx_data, 8'h5C);
        check("t5_frame_cnt", frame_cnt, 1);

        // 6: counter wrap and refused write
        force dut.r_frame_cnt = 16'hFFFF;
        tick(1);
        release dut.r_frame_cnt;
        tick(1);
        check("t6_preload", frame_cnt, 16'hFFFF);
        tx_data = 8'hAA; tx_valid = 1'b1; tick(1);
        tx_data = 8'h55; tick(1); tx_valid = 1'b0;
        check("t6_tx_ready_busy", tx_ready, 0);
        ss_low();
        spi_bits(8'h0F, 8, mi);
        ss_high();
        check("t6_miso", mi, 8'hAA);
        check("t6_wrap", frame_cnt, 0);
        check("t6_rx_data", rx_data, 8'h0F);
        ss_low();
        spi_bits(8'h3C, 8, mi);
        ss_high();
        check("t6_dropped", mi, fb_t6);
        check("t6_frame_cnt", frame_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
